serial_deser_rx: RTL and testbench
==================================

# serial_deser_rx

Serial-to-parallel receiver that reassembles words from a 1-bit stream produced by the team's universal shift register (its `s_left_dout`/`s_right_dout` taps). Bits arrive qualified by an enable and framed by a sync marker. Each bit order is selected at word start. Completed words leave through a one-entry valid/ready output register, so assembly of the next word overlaps the downstream stall. Overrun and framing errors are flagged for the control logic.

## Interface
- `WIDTH`, default 4: word width in bits; legal range ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `s_en`  in  1  serial bit valid this cycle; all other `s_*` inputs are ignored when low.
- `s_din`  in  1  serial data bit.
- `s_sync`  in  1  word-start marker, qualified by `s_en`.
- `s_dir`  in  1  bit order: 0 = LSB-first (bit enters at MSB, shifts right), 1 = MSB-first (bit enters at LSB, shifts left). Sampled only on the sync bit and held for the word.
- `flush`  in  1  synchronous abort: discard the partial word and return to IDLE.
- `clr_ovf`  in  1  clears sticky `overflow`.
- `m_data`  out  WIDTH  assembled word.
- `m_valid`  out  1  `m_data` holds an unconsumed word.
- `m_ready`  in  1  downstream accepts the word when `m_valid & m_ready`.
- `overflow`  out  1  sticky: a completed word was dropped.
- `frame_err`  out  1  one-cycle pulse: sync arrived mid-word.
- `busy`  out  1  a partial word is in progress (state SHIFT and `bit_cnt != 0`).

## Operation
- FSM states: IDLE, SHIFT. Reset enters IDLE.
- IDLE: bits without sync are discarded. `s_en & s_sync` latches `s_dir`, shifts `s_din` in as bit 0, sets `bit_cnt` = 1, and goes to SHIFT.
- SHIFT: each `s_en` shifts one bit in the latched direction and increments `bit_cnt`.
  - On the WIDTH-th bit the word completes and `bit_cnt` wraps to 0.
  - The FSM stays in SHIFT, so framing is continuous and the next bit starts a new word without a sync. That first bit uses the latched direction unless it carries sync.
- Sync in SHIFT with `bit_cnt` = 0 is a normal re-frame: `s_dir` is re-latched and there is no error.
- Sync in SHIFT with `bit_cnt` ≠ 0:
  - the partial word is discarded;
  - the current bit becomes bit 0 of a new word;
  - `s_dir` is re-latched;
  - `frame_err` pulses.
- `flush` overrides `s_en` in the same cycle: the partial word is discarded and the FSM goes to IDLE. The output register and `overflow` are not affected.
- Output register, on word completion:
  - If it is empty, or it is full and being drained this cycle, it loads the new word.
  - Otherwise the new word is dropped, the register is unchanged, and `overflow` is set.
- `clr_ovf` has priority over a same-cycle set: the flag clears, and the set applies the following cycle if the condition persists.
- Reset values: `m_data` = 0, `m_valid` = 0, `overflow` = 0, `frame_err` = 0, `busy` = 0, shift register = 0, `bit_cnt` = 0. The latched direction resets to 0.

## Timing
- Word complete on the rising edge ending cycle N → `m_valid`=1 with `m_data` valid in cycle N+1.
- Transfer occurs on the edge where `m_valid & m_ready`. `m_valid` drops the next cycle unless a new word completes on the same edge, in which case `m_valid` stays 1 with the new data.
- `m_data` is stable while `m_valid & !m_ready`.
- Gaps in `s_en` stall assembly indefinitely; no timeout.
- `frame_err` is high for exactly the cycle after the offending sync edge.
- Reset assertion mid-word immediately forces all outputs to reset values, independent of `clk`. After deassertion, the block waits in IDLE for a sync.
- Throughput: one bit per cycle sustained, with a completed word every WIDTH cycles without loss as long as `m_ready` is high at least once per WIDTH cycles.

## Structure
- Package `serial_deser_pkg` holds:
  - the state enum (IDLE, SHIFT);
  - constants `DIR_LSB_FIRST`=1'b0 and `DIR_MSB_FIRST`=1'b1, shared with the shift-register control logic.
- One sub-module, `deser_out_reg`: a WIDTH-wide valid/ready holding register with the overflow/drop rule. The top level holds the FSM, bit counter and assembly shift register.

## Test plan
- LSB-first: sync + bits 1,0,1,1 on consecutive cycles, `m_ready`=1 → `m_data`=4'b1101, `m_valid` for one cycle, 1 cycle after the 4th bit.
- MSB-first: same bits with `s_dir`=1 → `m_data`=4'b1011. Then a continuous second word 0,1,1,0 without sync → 4'b0110.
- Backpressure: `m_ready`=0, two complete words 4'hD then 4'h6 → `m_data` stays 4'hD and `overflow`=1. Pulse `clr_ovf` → `overflow`=0. Raise `m_ready` → one transfer of 4'hD.
- Resync: sync, 2 bits, then sync with bits 0,0,1,1 → `frame_err` pulse one cycle after the second sync. Next word (LSB-first) = 4'b1100, with no stale bits.
- Gapped input: bits 1,1,0,1 with `s_en` low 3 cycles between each → same result as gapless (LSB-first 4'b1011). `busy`=1 throughout the gaps.
- Flush/reset mid-word: after 2 bits assert `flush` → `busy`=0, and a non-sync bit is ignored. Repeat with `rst_n` pulled low between clock edges → all outputs 0 immediately, and a held `m_valid` is cleared.

Source files
------------

// File: rtl/serial_deser_pkg.sv
// Shared types and constants for the serial deserializer receiver.
// The direction constants are also used by the shift-register control logic.
package serial_deser_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } deser_state_e;

   localparam logic DIR_LSB_FIRST = 1'b0;
   localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/deser_out_reg.sv
// One-entry valid/ready holding register for completed words.
// A word that arrives while the entry is full and not draining is dropped and flagged.
module deser_out_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             m_ready,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   output logic             overflow
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             ovf_q, ovf_d;
   logic             load;
   logic             drop;

   always_comb begin
      load    = in_valid && (!valid_q || m_ready);
      drop    = in_valid && valid_q && !m_ready;
      data_d  = data_q;
      valid_d = valid_q;
      ovf_d   = ovf_q;
      if (load) begin
         data_d  = in_data;
         valid_d = 1'b1;
      end else if (valid_q && m_ready) begin
         valid_d = 1'b0;
      end
      // Clearing wins; a persisting drop condition re-sets the flag next cycle.
      if (clr_ovf) begin
         ovf_d = 1'b0;
      end else if (drop) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   assign m_data   = data_q;
   assign m_valid  = valid_q;
   assign overflow = ovf_q;

endmodule

// File: rtl/serial_deser_rx.sv
// Serial-to-parallel receiver: sync-framed bit assembly with per-word bit order,
// feeding a one-entry output register so assembly overlaps downstream stalls.
module serial_deser_rx
   import serial_deser_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_en,
   input  logic             s_din,
   input  logic             s_sync,
   input  logic             s_dir,
   input  logic             flush,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             overflow,
   output logic             frame_err,
   output logic             busy,
   output logic [0:0]       dbg_state
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   deser_state_e     state_q, state_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic             dir_q, dir_d;
   logic             frame_err_q, frame_err_d;
   logic             word_done;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      sr_d        = sr_q;
      dir_d       = dir_q;
      frame_err_d = 1'b0;
      word_done   = 1'b0;
      if (flush) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
         sr_d      = '0;
      end else if (s_en) begin
         if (s_sync) begin
            // Start a fresh word from this bit alone so no partial bits leak in.
            dir_d       = s_dir;
            sr_d        = (s_dir == DIR_MSB_FIRST) ? {{(WIDTH-1){1'b0}}, s_din}
                                                   : {s_din, {(WIDTH-1){1'b0}}};
            bit_cnt_d   = CNT_W'(1);
            state_d     = SHIFT;
            frame_err_d = (state_q == SHIFT) && (bit_cnt_q != '0);
         end else if (state_q == SHIFT) begin
            sr_d = (dir_q == DIR_MSB_FIRST) ? {sr_q[WIDTH-2:0], s_din}
                                            : {s_din, sr_q[WIDTH-1:1]};
            if (bit_cnt_q == CNT_LAST) begin
               bit_cnt_d = '0;
               word_done = 1'b1;
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         sr_q        <= '0;
         dir_q       <= DIR_LSB_FIRST;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         sr_q        <= sr_d;
         dir_q       <= dir_d;
         frame_err_q <= frame_err_d;
      end
   end

   deser_out_reg #(.WIDTH(WIDTH)) u_out_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (word_done),
      .in_data  (sr_d),
      .m_ready  (m_ready),
      .clr_ovf  (clr_ovf),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .overflow (overflow)
   );

   assign frame_err = frame_err_q;
   assign busy      = (state_q == SHIFT) && (bit_cnt_q != '0);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_deser_rx.sv
// Directed bench for serial_deser_rx: framing, bit order, backpressure,
// resync, gapped input, flush and asynchronous reset.
module tb_serial_deser_rx;

   logic       clk;
   logic       rst_n;
   logic       s_en;
   logic       s_din;
   logic       s_sync;
   logic       s_dir;
   logic       flush;
   logic       clr_ovf;
   logic [3:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       overflow;
   logic       frame_err;
   logic       busy;
   logic [0:0] dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   serial_deser_rx #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_en      (s_en),
      .s_din     (s_din),
      .s_sync    (s_sync),
      .s_dir     (s_dir),
      .flush     (flush),
      .clr_ovf   (clr_ovf),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .overflow  (overflow),
      .frame_err (frame_err),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Outputs are sampled 1 ns after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic din, input logic sync, input logic dir);
      s_en   = 1'b1;
      s_din  = din;
      s_sync = sync;
      s_dir  = dir;
      tick();
      s_en   = 1'b0;
      s_sync = 1'b0;
   endtask

   task automatic idle(input int n);
      s_en   = 1'b0;
      s_sync = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst_n   = 1'b0;
      s_en    = 1'b0;
      s_din   = 1'b0;
      s_sync  = 1'b0;
      s_dir   = 1'b0;
      flush   = 1'b0;
      clr_ovf = 1'b0;
      m_ready = 1'b1;
      #12;
      check("rst_m_data", 32'(m_data), 32'h0);
      check("rst_m_valid", 32'(m_valid), 32'h0);
      check("rst_overflow", 32'(overflow), 32'h0);
      check("rst_frame_err", 32'(frame_err), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      idle(2);

      // Bits without sync in IDLE are discarded.
      send_bit(1'b1, 1'b0, 1'b0);
      check("idle_nosync_busy", 32'(busy), 32'h0);

      // LSB-first 1,0,1,1 -> 4'b1101
      send_bit(1'b1, 1'b1, 1'b0);
      check("lsb_busy", 32'(busy), 32'h1);
      send_bit(1'b0, 1'b0, 1'b0);
      send_bit(1'b1, 1'b0, 1'b0);
      check("lsb_valid_early", 32'(m_valid), 32'h0);
      send_bit(1'b1, 1'b0, 1'b0);
      check("lsb_valid", 32'(m_valid), 32'h1);
      check("lsb_data", 32'(m_data), 32'hD);
      check("lsb_busy_wrap", 32'(busy), 32'h0);
      idle(1);
      check("lsb_valid_drop", 32'(m_valid), 32'h0);

      // MSB-first 1,0,1,1 -> 4'b1011, then continuous 0,1,1,0 -> 4'b0110
      send_bit(1'b1, 1'b1, 1'b1);
      send_bit(1'b0, 1'b0, 1'b0);
      send_bit(1'b1, 1'b0, 1'b0);
      send_bit(1'b1, 1'b0, 1'b0);
      check("msb_valid", 32'(m_valid), 32'h1);
      check("msb_data", 32'(m_data), 32'hB);
      send_bit(1'b0, 1'b0, 1'b0);
      check("msb2_valid_drop", 32'(m_valid), 32'h0);
      send_bit(1'b1, 1'b0, 1'b0);
      send_bit(1'b1, 1'b0, 1'b0);
      send_bit(1'b0, 1'b0, 1'b0);
      check("msb2_valid", 32'(m_valid), 32'h1);
      check("msb2_data", 32'(m_data), 32'h6);
      idle(1);

      // Backpressure: D held, 6 dropped, overflow sticky then cleared.
      m_ready = 1'b0;
      send_bit(1'b1, 1'b1, 1'b0);
      send_bit(1'b0, 1'b0, 1'b0);
      send_bit(1'b1, 1'b0, 1'b0);
      send_bit(1'b1, 1'b0, 1'b0);
      check("bp_first_data", 32'(m_data), 32'hD);
      check("bp_no_ovf", 32'(overflow), 32'h0);
      send_bit(1'b0, 1'b0, 1'b0);
      send_bit(1'b1, 1'b0, 1'b0);
      send_bit(1'b1, 1'b0, 1'b0);
      send_bit(1'b0, 1'b0, 1'b0);
      check("bp_hold_data", 32'(m_data), 32'hD);
      check("bp_hold_valid", 32'(m_valid), 32'h1);
      check("bp_ovf", 32'(overflow), 32'h1);
      idle(2);
      check("bp_ovf_sticky", 32'(overflow), 32'h1);
      clr_ovf = 1'b1;
      idle(1);
      clr_ovf = 1'b0;
      check("bp_ovf_clr", 32'(overflow), 32'h0);
      check("bp_data_stable", 32'(m_data), 32'hD);
      m_ready = 1'b1;
      idle(1);
      check("bp_drain", 32'(m_valid), 32'h0);
      idle(1);
      check("bp_one_xfer", 32'(m_valid), 32'h0);

      // Resync mid-word: frame_err pulse, then clean 4'b1100.
      send_bit(1'b1, 1'b1, 1'b0);
      send_bit(1'b1, 1'b0, 1'b0);
      check("resync_fe_idle", 32'(frame_err), 32'h0);
      send_bit(1'b0, 1'b1, 1'b0);
      check("resync_fe", 32'(frame_err), 32'h1);
      send_bit(1'b0, 1'b0, 1'b0);
      check("resync_fe_pulse", 32'(frame_err), 32'h0);
      send_bit(1'b1, 1'b0, 1'b0);
      send_bit(1'b1, 1'b0, 1'b0);
      check("resync_valid", 32'(m_valid), 32'h1);
      check("resync_data", 32'(m_data), 32'hC);
      // Sync at a word boundary re-frames without error.
      send_bit(1'b1, 1'b1, 1'b0);
      check("reframe_no_fe", 32'(frame_err), 32'h0);
      flush = 1'b1;
      idle(1);
      flush = 1'b0;

      // Gapped LSB-first 1,1,0,1 -> 4'b1011
      send_bit(1'b1, 1'b1, 1'b0);
      idle(3);
      check("gap_busy1", 32'(busy), 32'h1);
      send_bit(1'b1, 1'b0, 1'b0);
      idle(3);
      check("gap_busy2", 32'(busy), 32'h1);
      send_bit(1'b0, 1'b0, 1'b0);
      idle(3);
      check("gap_busy3", 32'(busy), 32'h1);
      check("gap_valid_early", 32'(m_valid), 32'h0);
      send_bit(1'b1, 1'b0, 1'b0);
      check("gap_valid", 32'(m_valid), 32'h1);
      check("gap_data", 32'(m_data), 32'hB);
      idle(1);

      // Flush mid-word, with s_en high the same cycle.
      send_bit(1'b1, 1'b1, 1'b0);
      send_bit(1'b0, 1'b0, 1'b0);
      flush = 1'b1;
      send_bit(1'b1, 1'b0, 1'b0);
      flush = 1'b0;
      check("flush_busy", 32'(busy), 32'h0);
      check("flush_state", 32'(dbg_state), 32'h0);
      send_bit(1'b1, 1'b0, 1'b0);
      send_bit(1'b1, 1'b0, 1'b0);
      send_bit(1'b1, 1'b0, 1'b0);
      check("flush_ignore_busy", 32'(busy), 32'h0);
      check("flush_no_word", 32'(m_valid), 32'h0);

      // Async reset mid-word clears a held word immediately.
      m_ready = 1'b0;
      send_bit(1'b1, 1'b1, 1'b0);
      send_bit(1'b0, 1'b0, 1'b0);
      send_bit(1'b1, 1'b0, 1'b0);
      send_bit(1'b1, 1'b0, 1'b0);
      check("ar_held_valid", 32'(m_valid), 32'h1);
      send_bit(1'b1, 1'b1, 1'b0);
      send_bit(1'b0, 1'b0, 1'b0);
      check("ar_busy_before", 32'(busy), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_m_valid", 32'(m_valid), 32'h0);
      check("ar_m_data", 32'(m_data), 32'h0);
      check("ar_busy", 32'(busy), 32'h0);
      check("ar_overflow", 32'(overflow), 32'h0);
      check("ar_frame_err", 32'(frame_err), 32'h0);
      #1;
      rst_n = 1'b1;
      m_ready = 1'b1;
      send_bit(1'b1, 1'b0, 1'b0);
      check("ar_wait_sync", 32'(busy), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
